// File: rtl/mitm_cmd_decoder.sv
// mitm_cmd_decoder
// Host-command front end for the UART MITM. It decodes two-byte host commands
// (opcode, argument) into the board forward enables and the snoop select, and
// answers every completed command with one response byte.
// Ports:
//   clk, rst       system clock (rising edge), asynchronous active-high reset
//   rx_valid       one-cycle strobe from the PC-link uart_rx; rx_data valid
//   rx_data        received byte
//   tx_rdy         PC-link uart_tx is idle and can accept a byte
//   tx_en          one-cycle byte request to uart_tx
//   tx_data        response byte, held from tx_en until tx_rdy falls
//   fwd_en         bit0 forwards the board1 link, bit1 the board2 link
//   snoop_sel      0 mirrors board1 traffic to the PC, 1 mirrors board2
//   busy           high whenever the decoder is not idle
//   cmd_strobe     one-cycle pulse when a valid command executes
//   err_pulse      one-cycle pulse on unknown opcode, timeout or dropped byte
module mitm_cmd_decoder #(
    parameter int unsigned SYSTEM_CLOCK  = 32000000,
    parameter int unsigned BAUD_RATE     = 115200,
    parameter int unsigned TIMEOUT_BYTES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    input  logic       tx_rdy,
    output logic       tx_en,
    output logic [7:0] tx_data,
    output logic [1:0] fwd_en,
    output logic       snoop_sel,
    output logic       busy,
    output logic       cmd_strobe,
    output logic       err_pulse
);

    localparam int unsigned TO_CYC = TIMEOUT_BYTES * 10 * (SYSTEM_CLOCK / BAUD_RATE);
    localparam int unsigned CNT_W  = $clog2(TO_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TO_CYC - 1);

    localparam logic [7:0] OP_ENABLE  = 8'h65;
    localparam logic [7:0] OP_DISABLE = 8'h64;
    localparam logic [7:0] OP_SNOOP   = 8'h73;
    localparam logic [7:0] OP_READ    = 8'h72;
    localparam logic [7:0] RESP_ACK   = 8'h4B;
    localparam logic [7:0] RESP_NAK   = 8'h4E;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARG     = 3'd1,
        ST_EXEC    = 3'd2,
        ST_RESP    = 3'd3,
        ST_TX_WAIT = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       op_q, op_d;
    logic [1:0]       arg_q, arg_d;        // only the low two argument bits are ever used
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       fwd_q, fwd_d;
    logic             snoop_q, snoop_d;
    logic [7:0]       resp_q, resp_d;
    logic             tx_en_q, tx_en_d;
    logic             busy_q, busy_d;
    logic             cmd_q, cmd_d;
    logic             err_q, err_d;

    // Next-state, register updates and next values of every registered output.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        arg_d   = arg_q;
        cnt_d   = cnt_q;
        fwd_d   = fwd_q;
        snoop_d = snoop_q;
        resp_d  = resp_q;
        tx_en_d = 1'b0;
        cmd_d   = 1'b0;
        err_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (rx_valid) begin
                    op_d    = rx_data;
                    cnt_d   = '0;
                    state_d = ST_ARG;
                end
            end
            ST_ARG: begin
                // A byte arriving in the expiry cycle still counts as the argument.
                if (rx_valid) begin
                    arg_d   = rx_data[1:0];
                    state_d = ST_EXEC;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_EXEC: begin
                cmd_d   = 1'b1;
                resp_d  = RESP_ACK;
                state_d = ST_RESP;
                case (op_q)
                    OP_ENABLE:  fwd_d   = fwd_q | arg_q;
                    OP_DISABLE: fwd_d   = fwd_q & ~arg_q;
                    OP_SNOOP:   snoop_d = arg_q[0];
                    OP_READ:    resp_d  = {5'b0, snoop_q, fwd_q};
                    default: begin
                        cmd_d  = 1'b0;
                        err_d  = 1'b1;
                        resp_d = RESP_NAK;
                    end
                endcase
                // Host bytes are not accepted until the response is out.
                if (rx_valid) begin
                    err_d = 1'b1;
                end
            end
            ST_RESP: begin
                if (rx_valid) begin
                    err_d = 1'b1;
                end
                if (tx_rdy) begin
                    tx_en_d = 1'b1;
                    state_d = ST_TX_WAIT;
                end
            end
            ST_TX_WAIT: begin
                if (rx_valid) begin
                    err_d = 1'b1;
                end
                // uart_tx drops tx_rdy once it has taken the byte.
                if (!tx_rdy) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            arg_q   <= '0;
            cnt_q   <= '0;
            fwd_q   <= '0;
            snoop_q <= 1'b0;
            resp_q  <= '0;
            tx_en_q <= 1'b0;
            busy_q  <= 1'b0;
            cmd_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            arg_q   <= arg_d;
            cnt_q   <= cnt_d;
            fwd_q   <= fwd_d;
            snoop_q <= snoop_d;
            resp_q  <= resp_d;
            tx_en_q <= tx_en_d;
            busy_q  <= busy_d;
            cmd_q   <= cmd_d;
            err_q   <= err_d;
        end
    end

    assign tx_en      = tx_en_q;
    assign tx_data    = resp_q;
    assign fwd_en     = fwd_q;
    assign snoop_sel  = snoop_q;
    assign busy       = busy_q;
    assign cmd_strobe = cmd_q;
    assign err_pulse  = err_q;

endmodule

// File: tb/tb_mitm_cmd_decoder.sv
// Bench for mitm_cmd_decoder: directed command scenarios followed by random
// commands, checked against a small command-level model of the host protocol.
module tb_mitm_cmd_decoder;

    localparam int TO_CYC = 4 * 10 * (32000000 / 115200);

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       tx_rdy;
    logic       tx_en;
    logic [7:0] tx_data;
    logic [1:0] fwd_en;
    logic       snoop_sel;
    logic       busy;
    logic       cmd_strobe;
    logic       err_pulse;

    mitm_cmd_decoder dut (
        .clk        (clk),
        .rst        (rst),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .tx_rdy     (tx_rdy),
        .tx_en      (tx_en),
        .tx_data    (tx_data),
        .fwd_en     (fwd_en),
        .snoop_sel  (snoop_sel),
        .busy       (busy),
        .cmd_strobe (cmd_strobe),
        .err_pulse  (err_pulse)
    );

    always #5 clk = ~clk;

    // uart_tx stand-in: busy for a few cycles after each accepted byte.
    int   tx_cnt  = 0;
    logic tx_hold = 1'b0;
    always @(posedge clk) begin
        if (tx_en && tx_rdy) tx_cnt <= $urandom_range(6, 2);
        else if (tx_cnt != 0) tx_cnt <= tx_cnt - 1;
    end
    assign tx_rdy = (tx_cnt == 0) && !tx_hold;

    // Pulse counters.
    int n_cmd = 0, n_err = 0, n_txen = 0;
    always @(posedge clk) begin
        if (cmd_strobe === 1'b1) n_cmd++;
        if (err_pulse === 1'b1) n_err++;
        if (tx_en === 1'b1) n_txen++;
    end

    int n_tests = 0;
    int n_fail  = 0;

    // Host-visible model state.
    int fwd_m   = 0;
    int snoop_m = 0;
    int last_resp = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        step();
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic wait_resp(input string tag, output logic [7:0] d);
        bit got = 0;
        d = 8'h00;
        for (int i = 0; i < 500; i++) begin
            step();
            if (tx_en === 1'b1) begin
                got = 1;
                d   = tx_data;
                break;
            end
        end
        if (!got) chk({tag, "_resp_timeout"}, 32'(got), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        bit idle = 0;
        for (int i = 0; i < 200; i++) begin
            if (busy === 1'b0) begin
                idle = 1;
                break;
            end
            step();
        end
        if (!idle) chk({tag, "_idle_timeout"}, 32'(idle), 32'd1);
    endtask

    // Protocol model: returns the expected response and whether the opcode is known.
    task automatic model_cmd(input int op, input int arg, output int resp, output int ok);
        int lo = arg % 4;
        ok   = 1;
        resp = 'h4B;
        case (op)
            'h65: fwd_m = fwd_m | lo;
            'h64: fwd_m = fwd_m & (3 - lo);
            'h73: snoop_m = arg % 2;
            'h72: resp = snoop_m * 4 + fwd_m;
            default: begin
                ok   = 0;
                resp = 'h4E;
            end
        endcase
    endtask

    // Send one command with `gap` idle cycles between opcode and argument, then check everything.
    task automatic do_cmd(input string tag, input logic [7:0] op, input logic [7:0] arg, input int gap);
        int c0 = n_cmd, e0 = n_err, t0 = n_txen;
        int old_fwd = fwd_m, old_snoop = snoop_m;
        int resp, ok;
        logic [7:0] d;
        model_cmd(int'(op), int'(arg), resp, ok);
        put_byte(op);
        repeat (gap) step();
        put_byte(arg);
        chk({tag, "_fwd_pre"}, 32'(fwd_en), 32'(old_fwd));
        chk({tag, "_snoop_pre"}, 32'(snoop_sel), 32'(old_snoop));
        step();
        chk({tag, "_fwd"}, 32'(fwd_en), 32'(fwd_m));
        chk({tag, "_snoop"}, 32'(snoop_sel), 32'(snoop_m));
        chk({tag, "_txen_early"}, 32'(tx_en), 32'd0);
        wait_resp(tag, d);
        chk({tag, "_resp"}, 32'(d), 32'(resp));
        last_resp = int'(d);
        wait_idle(tag);
        step();
        chk({tag, "_cmd_cnt"}, 32'(n_cmd - c0), 32'(ok));
        chk({tag, "_err_cnt"}, 32'(n_err - e0), 32'(1 - ok));
        chk({tag, "_txen_cnt"}, 32'(n_txen - t0), 32'd1);
    endtask

    initial begin
        int e0, t0, resp, ok;
        logic [7:0] d;
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_fwd", 32'(fwd_en), 32'd0);
        chk("rst_snoop", 32'(snoop_sel), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_txen", 32'(tx_en), 32'd0);
        chk("rst_txdata", 32'(tx_data), 32'd0);
        chk("rst_cmd", 32'(cmd_strobe), 32'd0);
        chk("rst_err", 32'(err_pulse), 32'd0);
        rst = 1'b0;
        step();

        do_cmd("t1_enable", 8'h65, 8'h03, 0);
        chk("t1_fwd_const", 32'(fwd_en), 32'd3);
        chk("t1_resp_const", 32'(last_resp), 32'h4B);
        do_cmd("t2_disable", 8'h64, 8'h01, 2);
        chk("t2_fwd_const", 32'(fwd_en), 32'd2);
        do_cmd("t3_snoop", 8'h73, 8'h01, 1);
        do_cmd("t3_read", 8'h72, 8'h00, 0);
        chk("t3_status_const", 32'(last_resp), 32'h06);
        do_cmd("t4_unknown", 8'h41, 8'h00, 0);
        chk("t4_resp_const", 32'(last_resp), 32'h4E);

        // Bytes arriving in EXEC and while RESP is stalled are dropped with an error.
        e0 = n_err;
        t0 = n_txen;
        tx_hold = 1'b1;
        model_cmd('h72, 0, resp, ok);
        put_byte(8'h72);
        put_byte(8'h00);
        put_byte(8'hAA);
        repeat (3) step();
        chk("drop_busy", 32'(busy), 32'd1);
        chk("drop_no_txen", 32'(n_txen - t0), 32'd0);
        put_byte(8'h55);
        tx_hold = 1'b0;
        wait_resp("drop", d);
        chk("drop_resp", 32'(d), 32'(resp));
        wait_idle("drop");
        step();
        chk("drop_err_cnt", 32'(n_err - e0), 32'd2);

        // Argument timeout: nothing in ARG for TO_CYC cycles.
        e0 = n_err;
        t0 = n_txen;
        put_byte(8'h65);
        repeat (TO_CYC - 1) step();
        chk("t5_busy_before", 32'(busy), 32'd1);
        chk("t5_err_before", 32'(n_err - e0), 32'd0);
        step();
        chk("t5_err_pulse", 32'(err_pulse), 32'd1);
        chk("t5_busy_after", 32'(busy), 32'd0);
        step();
        chk("t5_err_once", 32'(err_pulse), 32'd0);
        chk("t5_no_txen", 32'(n_txen - t0), 32'd0);
        do_cmd("t5_enable", 8'h65, 8'h01, 0);
        chk("t5_fwd_bit0", 32'(fwd_en[0]), 32'd1);

        // Argument in the very last cycle before expiry is accepted.
        do_cmd("edge_arg", 8'h73, 8'h00, TO_CYC - 1);

        // Reset while waiting for uart_tx to take the response.
        do_cmd("t6_setup", 8'h65, 8'h03, 0);
        put_byte(8'h72);
        put_byte(8'h00);
        wait_resp("t6", d);
        chk("t6_busy_pre", 32'(busy), 32'd1);
        chk("t6_fwd_pre", 32'(fwd_en), 32'd3);
        rst = 1'b1;
        #1;
        chk("t6_fwd", 32'(fwd_en), 32'd0);
        chk("t6_snoop", 32'(snoop_sel), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_txen", 32'(tx_en), 32'd0);
        chk("t6_txdata", 32'(tx_data), 32'd0);
        fwd_m   = 0;
        snoop_m = 0;
        step();
        rst = 1'b0;
        step();
        do_cmd("t6_after", 8'h65, 8'h02, 0);

        // Random commands against the model.
        for (int k = 0; k < 40; k++) begin
            logic [7:0] op;
            logic [7:0] arg;
            int sel = int'($urandom_range(5, 0));
            case (sel)
                0: op = 8'h65;
                1: op = 8'h64;
                2: op = 8'h73;
                3: op = 8'h72;
                4: op = 8'h65;
                default: op = 8'($urandom());
            endcase
            arg = 8'($urandom());
            do_cmd($sformatf("rnd%0d", k), op, arg, int'($urandom_range(5, 0)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
